// File: rtl/muldiv_iter.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and restoring divide,
// fixed XLEN+2 cycle latency under a start/busy/done handshake.
module muldiv_iter #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            kill_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] src1_i,
   input  logic [XLEN-1:0] src2_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int unsigned     CntW     = $clog2(XLEN) + 1;
   localparam logic [CntW-1:0] LastIter = CntW'(XLEN - 1);
   localparam logic [XLEN-1:0] MinNeg   = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e              state_q, state_d;
   logic [2:0]          op_q;
   logic                neg_q, div_zero_q, ovf_q;
   logic [XLEN-1:0]     src1_q, opnd_q;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [XLEN-1:0]     rem_q, rem_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [XLEN-1:0]     result_q, result_d;

   logic                accept;
   logic                s1_signed, s2_signed, neg1, neg2, sign_in, ovf_in;
   logic [XLEN-1:0]     mag1, mag2;
   logic [XLEN:0]       sum, shifted;
   logic [2*XLEN-1:0]   prod_fix;
   logic [XLEN-1:0]     quo_fix, rem_fix, fix_result;

   assign accept = start_i && (state_q == StIdle || state_q == StDone);

   always_comb begin
      s1_signed = op_i inside {3'b001, 3'b010, 3'b100, 3'b110};
      s2_signed = op_i inside {3'b001, 3'b100, 3'b110};
      neg1      = s1_signed & src1_i[XLEN-1];
      neg2      = s2_signed & src2_i[XLEN-1];
      mag1      = neg1 ? -src1_i : src1_i;
      mag2      = neg2 ? -src2_i : src2_i;
      // Remainder takes the dividend's sign; product and quotient take the XOR.
      sign_in   = (op_i[2] && op_i[1]) ? neg1 : (neg1 ^ neg2);
      ovf_in    = (op_i == 3'b100 || op_i == 3'b110) && (src1_i == MinNeg) && (&src2_i);
   end

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle, StDone: state_d = start_i ? StCalc : StIdle;
         StCalc: begin
            if (kill_i) begin
               state_d = StIdle;
            end else if (cnt_q == LastIter) begin
               state_d = StFix;
            end
         end
         StFix:   state_d = kill_i ? StIdle : StDone;
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from state and registers only
   always_comb begin
      busy_o   = (state_q == StCalc) || (state_q == StFix);
      done_o   = (state_q == StDone);
      result_o = result_q;
   end

   always_comb begin
      prod_fix = neg_q ? -acc_q : acc_q;
      quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      rem_fix  = neg_q ? -rem_q : rem_q;
      case (op_q)
         3'b000:                 fix_result = prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fix_result = div_zero_q ? '1 : (ovf_q ? src1_q : quo_fix);
         default:                fix_result = div_zero_q ? src1_q : (ovf_q ? '0 : rem_fix);
      endcase
   end

   // Multiply keeps the multiplier in acc low half; divide keeps the dividend there and
   // shifts quotient bits in behind it.
   always_comb begin
      acc_d    = acc_q;
      rem_d    = rem_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      shifted  = {rem_q, acc_q[XLEN-1]};
      if (accept) begin
         cnt_d = '0;
         rem_d = '0;
         acc_d = {{XLEN{1'b0}}, (op_i[2] ? mag1 : mag2)};
      end else if (state_q == StCalc) begin
         cnt_d = cnt_q + 1'b1;
         if (!op_q[2]) begin
            acc_d = {sum, acc_q[XLEN-1:1]};
         end else if (shifted >= {1'b0, opnd_q}) begin
            rem_d = XLEN'(shifted - {1'b0, opnd_q});
            acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b1};
         end else begin
            rem_d = shifted[XLEN-1:0];
            acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b0};
         end
      end else if (state_q == StFix && !kill_i) begin
         result_d = fix_result;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         op_q       <= '0;
         opnd_q     <= '0;
         neg_q      <= 1'b0;
         div_zero_q <= 1'b0;
         ovf_q      <= 1'b0;
         src1_q     <= '0;
         acc_q      <= '0;
         rem_q      <= '0;
         cnt_q      <= '0;
         result_q   <= '0;
      end else begin
         acc_q    <= acc_d;
         rem_q    <= rem_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         if (accept) begin
            op_q       <= op_i;
            opnd_q     <= op_i[2] ? mag2 : mag1;
            neg_q      <= sign_in;
            div_zero_q <= (src2_i == '0);
            ovf_q      <= ovf_in;
            src1_q     <= src1_i;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: four instances (XLEN 8/16/32/64) checked against directed vectors,
// handshake corner sequences and a wide-integer arithmetic reference model.
module tb_muldiv_iter;

   typedef logic signed [129:0] wide_t;

   typedef struct {
      int          k;
      logic [2:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
   } vec_t;

   logic        clk, rst;
   logic [3:0]  start, kill, busy, done;
   logic [2:0]  op [4];
   logic [63:0] s1 [4];
   logic [63:0] s2 [4];
   logic [7:0]  r8;
   logic [15:0] r16;
   logic [31:0] r32;
   logic [63:0] r64;

   int checks = 0;
   int failures = 0;

   muldiv_iter #(.XLEN(8)) u_dut8 (
      .clk_i(clk), .rst_i(rst), .start_i(start[0]), .kill_i(kill[0]), .op_i(op[0]),
      .src1_i(s1[0][7:0]), .src2_i(s2[0][7:0]),
      .busy_o(busy[0]), .done_o(done[0]), .result_o(r8)
   );
   muldiv_iter #(.XLEN(16)) u_dut16 (
      .clk_i(clk), .rst_i(rst), .start_i(start[1]), .kill_i(kill[1]), .op_i(op[1]),
      .src1_i(s1[1][15:0]), .src2_i(s2[1][15:0]),
      .busy_o(busy[1]), .done_o(done[1]), .result_o(r16)
   );
   muldiv_iter #(.XLEN(32)) u_dut32 (
      .clk_i(clk), .rst_i(rst), .start_i(start[2]), .kill_i(kill[2]), .op_i(op[2]),
      .src1_i(s1[2][31:0]), .src2_i(s2[2][31:0]),
      .busy_o(busy[2]), .done_o(done[2]), .result_o(r32)
   );
   muldiv_iter #(.XLEN(64)) u_dut64 (
      .clk_i(clk), .rst_i(rst), .start_i(start[3]), .kill_i(kill[3]), .op_i(op[3]),
      .src1_i(s1[3]), .src2_i(s2[3]),
      .busy_o(busy[3]), .done_o(done[3]), .result_o(r64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] get_res(int k);
      case (k)
         0:       return {56'b0, r8};
         1:       return {48'b0, r16};
         2:       return {32'b0, r32};
         default: return r64;
      endcase
   endfunction

   function automatic logic [63:0] wmask(int w);
      return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
   endfunction

   function automatic wide_t zx(logic [63:0] v, int w);
      wide_t r;
      r = '0;
      r[63:0] = v & wmask(w);
      return r;
   endfunction

   function automatic wide_t sx(logic [63:0] v, int w);
      wide_t r, p;
      r = zx(v, w);
      p = '0;
      p[w] = 1'b1;
      if (v[w-1]) r = r - p;
      return r;
   endfunction

   // Reference: RISC-V M semantics on unbounded-width signed integers.
   function automatic logic [63:0] model(int w, logic [2:0] o, logic [63:0] a, logic [63:0] b);
      wide_t sa, sb, ua, ub, r;
      logic  ovf;
      sa  = sx(a, w);
      sb  = sx(b, w);
      ua  = zx(a, w);
      ub  = zx(b, w);
      ovf = ((a & wmask(w)) == (64'd1 << (w - 1))) && ((b & wmask(w)) == wmask(w));
      case (o)
         3'd0: r = ua * ub;
         3'd1: r = (sa * sb) >>> w;
         3'd2: r = (sa * ub) >>> w;
         3'd3: r = (ua * ub) >>> w;
         3'd4: r = (ub == 0) ? -1 : (ovf ? sa : sa / sb);
         3'd5: r = (ub == 0) ? -1 : ua / ub;
         3'd6: r = (ub == 0) ? sa : (ovf ? 0 : sa % sb);
         default: r = (ub == 0) ? ua : ua % ub;
      endcase
      return r[63:0] & wmask(w);
   endfunction

   function automatic logic [63:0] pick(int w);
      case ($urandom_range(0, 6))
         0:       return 64'd0;
         1:       return wmask(w);
         2:       return 64'd1 << (w - 1);
         3:       return 64'd1;
         default: return {$urandom, $urandom} & wmask(w);
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one op, return result, cycles from issue to done, and busy-cycle count.
   task automatic run_op(input int k, input logic [2:0] o, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] res, output int lat,
                         output int bcnt);
      @(negedge clk);
      start[k] = 1'b1;
      op[k] = o;
      s1[k] = a;
      s2[k] = b;
      lat = 0;
      bcnt = 0;
      do begin
         @(negedge clk);
         start[k] = 1'b0;
         lat++;
         if (busy[k]) bcnt++;
      end while (!done[k] && lat < 300);
      res = get_res(k);
   endtask

   task automatic start_only(input int k, input logic [2:0] o, input logic [63:0] a,
                             input logic [63:0] b);
      @(negedge clk);
      start[k] = 1'b1;
      op[k] = o;
      s1[k] = a;
      s2[k] = b;
      @(negedge clk);
      start[k] = 1'b0;
   endtask

   vec_t        vecs[$];
   logic [63:0] res, exp;
   int          lat, bcnt, ndone, w;

   initial begin
      rst = 1'b1;
      start = '0;
      kill = '0;
      for (int i = 0; i < 4; i++) begin
         op[i] = '0;
         s1[i] = '0;
         s2[i] = '0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("reset_busy%0d", k), {63'b0, busy[k]}, 64'd0);
         check($sformatf("reset_done%0d", k), {63'b0, done[k]}, 64'd0);
         check($sformatf("reset_result%0d", k), get_res(k), 64'd0);
      end
      rst = 1'b0;

      vecs.push_back('{2, 3'b000, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h0000_0001});
      vecs.push_back('{2, 3'b011, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE});
      vecs.push_back('{2, 3'b001, 64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFF});
      vecs.push_back('{2, 3'b010, 64'hFFFF_FFF9, 64'hFFFF_FFFF, 64'hFFFF_FFF9});
      vecs.push_back('{2, 3'b100, 64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFD});
      vecs.push_back('{2, 3'b110, 64'hFFFF_FFF9, 64'h2, 64'hFFFF_FFFF});
      vecs.push_back('{2, 3'b101, 64'hFFFF_FFF9, 64'h2, 64'h7FFF_FFFC});
      vecs.push_back('{2, 3'b100, 64'h5, 64'h0, 64'hFFFF_FFFF});
      vecs.push_back('{2, 3'b111, 64'h5, 64'h0, 64'h5});
      vecs.push_back('{2, 3'b100, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000});
      vecs.push_back('{2, 3'b110, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0});
      vecs.push_back('{0, 3'b010, 64'h80, 64'hFF, 64'h80});
      vecs.push_back('{1, 3'b101, 64'h1234, 64'h0, 64'hFFFF});
      vecs.push_back('{3, 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                       64'hFFFF_FFFF_FFFF_FFFE});
      vecs.push_back('{3, 3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                       64'h8000_0000_0000_0000});

      for (int i = 0; i < vecs.size(); i++) begin
         w = 8 << vecs[i].k;
         run_op(vecs[i].k, vecs[i].op, vecs[i].a, vecs[i].b, res, lat, bcnt);
         check($sformatf("vec%0d_result", i), res, vecs[i].exp);
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(w + 2));
         check($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'(w + 1));
      end

      // Single-cycle done pulse
      @(negedge clk);
      check("done_pulse_width", {63'b0, done[3]}, 64'd0);

      // Back-to-back issue with start held high
      @(negedge clk);
      start[2] = 1'b1;
      op[2] = 3'b000;
      s1[2] = 64'd3;
      s2[2] = 64'd5;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done[2] && lat < 300);
      check("b2b_first_lat", 64'(lat), 64'd34);
      check("b2b_first_res", get_res(2), 64'd15);
      op[2] = 3'b101;
      s1[2] = 64'd100;
      s2[2] = 64'd7;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!done[2] && lat < 300);
      start[2] = 1'b0;
      check("b2b_second_lat", 64'(lat), 64'd34);
      check("b2b_second_res", get_res(2), 64'd14);
      @(negedge clk);
      check("b2b_done_drop", {63'b0, done[2]}, 64'd0);

      // Start mid-CALC is ignored
      start_only(2, 3'b000, 64'd6, 64'd7);
      lat = 1;
      while (!done[2] && lat < 300) begin
         @(negedge clk);
         lat++;
         start[2] = (lat == 5);
         if (lat == 5) begin
            op[2] = 3'b100;
            s1[2] = 64'd100;
            s2[2] = 64'd3;
         end
      end
      start[2] = 1'b0;
      check("ignored_start_lat", 64'(lat), 64'd34);
      check("ignored_start_res", get_res(2), 64'd42);
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (done[2]) ndone++;
      end
      check("ignored_start_no_extra_done", 64'(ndone), 64'd0);

      // Kill at CALC cycle 10
      start_only(2, 3'b000, 64'd9, 64'd9);
      repeat (9) @(negedge clk);
      kill[2] = 1'b1;
      @(negedge clk);
      kill[2] = 1'b0;
      check("kill_busy", {63'b0, busy[2]}, 64'd0);
      check("kill_result_kept", get_res(2), 64'd42);
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         if (done[2]) ndone++;
      end
      check("kill_no_done", 64'(ndone), 64'd0);

      // Reset mid-operation
      start_only(2, 3'b101, 64'd1000, 64'd3);
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midreset_busy", {63'b0, busy[2]}, 64'd0);
      check("midreset_done", {63'b0, done[2]}, 64'd0);
      check("midreset_result", get_res(2), 64'd0);
      run_op(2, 3'b101, 64'd1000, 64'd3, res, lat, bcnt);
      check("post_reset_res", res, 64'd333);
      check("post_reset_lat", 64'(lat), 64'd34);

      // Random compare against the reference model
      for (int k = 1; k < 4; k += 2) begin
         w = 8 << k;
         for (int n = 0; n < 40; n++) begin
            logic [2:0]  ro;
            logic [63:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = pick(w);
            rb = pick(w);
            exp = model(w, ro, ra, rb);
            run_op(k, ro, ra, rb, res, lat, bcnt);
            check($sformatf("rand_x%0d_op%0d_%h_%h", w, ro, ra, rb), res, exp);
            check($sformatf("rand_x%0d_lat", w), 64'(lat), 64'(w + 2));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
